ray_cast_scheduler: RTL and testbench

//  Per-frame ray scheduler for the raycaster. Sweeps NUM_COLS screen columns and computes each ray angle in fixed point.

---
 rtl/ray_cast_scheduler.sv | 272 +++++++++++++++++++++++++++
 tb/tb_ray_cast_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_cast_scheduler.sv
// ray_cast_scheduler
//  Per-frame ray scheduler for the raycaster. Sweeps NUM_COLS screen columns,
//  steps the ray angle in fixed point (integer degrees + 1/1024 degree fraction),
//  launches the horizontal and vertical wall-intersection engines together,
//  collects both results, picks the nearer hit and writes it to the column buffer.
//
//  Optional build macro: RAY_TIMEOUT_EN
//    defined   - per-ray watchdog in WAIT; missing engine results after
//                TIMEOUT_CYC cycles are treated as "no wall"; adds the
//                sticky output timeout_seen (cleared on LATCH).
//    undefined - WAIT blocks until both engines report.
//
//  Ports
//    clock, resetn            clock, synchronous active-low reset
//    start_frame              frame request, honoured only in IDLE
//    player_X/Y, view_ang_X/Y player position and view angle, latched at frame start
//    ray_X/Y, ray_alpha_X/Y   ray origin and angle presented to both engines
//    begin_h/v                one-cycle engine launch pulses
//    h_end/v_end, h_found/v_found, h_wallX/Y, v_wallX/Y   engine results
//    col_we, col_addr, col_dist, col_side                 column-buffer write
//    frame_busy, frame_done   sweep status
//    timeout_seen             (RAY_TIMEOUT_EN only) a ray hit the watchdog
//
//  state  | meaning
//  IDLE   | waiting for start_frame
//  LATCH  | capture player/view, compute first ray angle
//  LAUNCH | begin_h/begin_v high, result flags cleared
//  WAIT   | collecting h_end / v_end
//  SELECT | choose nearer hit, arm the column write
//  WRITE  | col_we high
//  NEXT   | advance column and angle, or finish the frame

module ray_cast_scheduler #(
    parameter int NUM_COLS    = 160,
    parameter int HALF_FOV_X  = 30,
    parameter int STEP_X      = 0,
    parameter int STEP_Y      = 384,
`ifdef RAY_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 1024,
`endif
    localparam int COL_W      = $clog2(NUM_COLS)
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    start_frame,
    input  logic signed [12:0]      player_X,
    input  logic signed [12:0]      player_Y,
    input  logic [9:0]              view_ang_X,
    input  logic [9:0]              view_ang_Y,
    output logic signed [12:0]      ray_X,
    output logic signed [12:0]      ray_Y,
    output logic [9:0]              ray_alpha_X,
    output logic [9:0]              ray_alpha_Y,
    output logic                    begin_h,
    output logic                    begin_v,
    input  logic                    h_end,
    input  logic                    v_end,
    input  logic                    h_found,
    input  logic                    v_found,
    input  logic signed [12:0]      h_wallX,
    input  logic signed [12:0]      h_wallY,
    input  logic signed [12:0]      v_wallX,
    input  logic signed [12:0]      v_wallY,
    output logic                    col_we,
    output logic [COL_W-1:0]        col_addr,
    output logic [12:0]             col_dist,
    output logic                    col_side,
    output logic                    frame_busy,
    output logic                    frame_done
`ifdef RAY_TIMEOUT_EN
    ,
    output logic                    timeout_seen
`endif
);

    typedef enum logic [2:0] {
        IDLE, LATCH, LAUNCH, WAIT, SELECT, WRITE, NEXT
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    state_t             state;
    logic [COL_W-1:0]   col;
    logic               h_done, v_done;
    logic               h_hit, v_hit;
    logic signed [12:0] h_x, h_y, v_x, v_y;

`ifdef RAY_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] to_cnt;
`endif

    // Chebyshev distance: both hits sit on the same ray, so max(|dx|,|dy|)
    // orders them exactly without a multiplier.
    function automatic logic [12:0] cheb(input logic signed [12:0] wx,
                                         input logic signed [12:0] wy,
                                         input logic signed [12:0] rx,
                                         input logic signed [12:0] ry);
        logic signed [13:0] dx, dy;
        logic [13:0]        ax, ay;
        dx = {wx[12], wx} - {rx[12], rx};
        dy = {wy[12], wy} - {ry[12], ry};
        ax = dx[13] ? 14'(-dx) : 14'(dx);
        ay = dy[13] ? 14'(-dy) : 14'(dy);
        return (ax >= ay) ? ax[12:0] : ay[12:0];
    endfunction

    logic [12:0] d_h, d_v, sel_dist;
    logic        sel_side;

    always_comb begin
        d_h      = cheb(h_x, h_y, ray_X, ray_Y);
        d_v      = cheb(v_x, v_y, ray_X, ray_Y);
        sel_dist = 13'h1FFF;
        sel_side = 1'b0;
        if (h_hit && v_hit) begin
            // tie goes to the horizontal-grid hit
            if (d_v < d_h) begin
                sel_dist = d_v;
                sel_side = 1'b1;
            end else begin
                sel_dist = d_h;
            end
        end else if (h_hit) begin
            sel_dist = d_h;
        end else if (v_hit) begin
            sel_dist = d_v;
            sel_side = 1'b1;
        end
    end

    // First ray angle: view - HALF_FOV_X, folded back into 0..359.
    logic [11:0] a_start;
    always_comb begin
        a_start = {2'b00, view_ang_X} + 12'd360 - 12'(HALF_FOV_X);
        if (a_start >= 12'd360)
            a_start = a_start - 12'd360;
    end

    // Per-column step with fraction carry into the integer degrees.
    logic [10:0] frac_sum;
    logic [10:0] ang_sum;
    always_comb begin
        frac_sum = {1'b0, ray_alpha_Y} + 11'(STEP_Y);
        ang_sum  = {1'b0, ray_alpha_X} + 11'(STEP_X) + {10'd0, frac_sum[10]};
        if (ang_sum >= 11'd360)
            ang_sum = ang_sum - 11'd360;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            col         <= '0;
            h_done      <= 1'b0;
            v_done      <= 1'b0;
            h_hit       <= 1'b0;
            v_hit       <= 1'b0;
            h_x         <= '0;
            h_y         <= '0;
            v_x         <= '0;
            v_y         <= '0;
            ray_X       <= '0;
            ray_Y       <= '0;
            ray_alpha_X <= '0;
            ray_alpha_Y <= '0;
            begin_h     <= 1'b0;
            begin_v     <= 1'b0;
            col_we      <= 1'b0;
            col_addr    <= '0;
            col_dist    <= '0;
            col_side    <= 1'b0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
`ifdef RAY_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_seen <= 1'b0;
`endif
        end else begin
            begin_h    <= 1'b0;
            begin_v    <= 1'b0;
            col_we     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        frame_busy <= 1'b1;
                        state      <= LATCH;
                    end
                end
                LATCH: begin
                    ray_X       <= player_X;
                    ray_Y       <= player_Y;
                    ray_alpha_X <= a_start[9:0];
                    ray_alpha_Y <= view_ang_Y;
                    col         <= '0;
                    begin_h     <= 1'b1;
                    begin_v     <= 1'b1;
`ifdef RAY_TIMEOUT_EN
                    timeout_seen <= 1'b0;
`endif
                    state       <= LAUNCH;
                end
                LAUNCH: begin
                    h_done <= 1'b0;
                    v_done <= 1'b0;
                    h_hit  <= 1'b0;
                    v_hit  <= 1'b0;
`ifdef RAY_TIMEOUT_EN
                    to_cnt <= TO_W'(TIMEOUT_CYC - 1);
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (h_end && !h_done) begin
                        h_done <= 1'b1;
                        h_hit  <= h_found;
                        h_x    <= h_wallX;
                        h_y    <= h_wallY;
                    end
                    if (v_end && !v_done) begin
                        v_done <= 1'b1;
                        v_hit  <= v_found;
                        v_x    <= v_wallX;
                        v_y    <= v_wallY;
                    end
                    if ((h_done || h_end) && (v_done || v_end)) begin
                        state <= SELECT;
                    end
`ifdef RAY_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        // an engine that has not answered counts as "no wall"
                        if (!h_done && !h_end) h_hit <= 1'b0;
                        if (!v_done && !v_end) v_hit <= 1'b0;
                        timeout_seen <= 1'b1;
                        state        <= SELECT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                SELECT: begin
                    col_dist <= sel_dist;
                    col_side <= sel_side;
                    col_addr <= col;
                    col_we   <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (col == LAST_COL) begin
                        frame_busy <= 1'b0;
                        frame_done <= 1'b1;
                    end
                    state <= NEXT;
                end
                NEXT: begin
                    if (col == LAST_COL) begin
                        state <= IDLE;
                    end else begin
                        col         <= col + 1'b1;
                        ray_alpha_X <= ang_sum[9:0];
                        ray_alpha_Y <= frac_sum[9:0];
                        begin_h     <= 1'b1;
                        begin_v     <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_cast_scheduler.sv
// Directed testbench for ray_cast_scheduler. A behavioural engine pair answers
// each launch three cycles later with programmable results; a monitor logs
// column writes and ray angles for the checks in the main sequence.
module tb_ray_cast_scheduler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               resetn = 1'b0;
    logic               start_frame = 1'b0;
    logic signed [12:0] player_X = '0, player_Y = '0;
    logic [9:0]         view_ang_X = '0, view_ang_Y = '0;
    logic signed [12:0] ray_X, ray_Y;
    logic [9:0]         ray_alpha_X, ray_alpha_Y;
    logic               begin_h, begin_v;
    logic               h_end = 1'b0, v_end = 1'b0, h_found = 1'b0, v_found = 1'b0;
    logic signed [12:0] h_wallX = '0, h_wallY = '0, v_wallX = '0, v_wallY = '0;
    logic               col_we;
    logic [7:0]         col_addr;
    logic [12:0]        col_dist;
    logic               col_side, frame_busy, frame_done;
`ifdef RAY_TIMEOUT_EN
    logic               timeout_seen;
`endif

    ray_cast_scheduler dut (
        .clock(clock), .resetn(resetn), .start_frame(start_frame),
        .player_X(player_X), .player_Y(player_Y),
        .view_ang_X(view_ang_X), .view_ang_Y(view_ang_Y),
        .ray_X(ray_X), .ray_Y(ray_Y),
        .ray_alpha_X(ray_alpha_X), .ray_alpha_Y(ray_alpha_Y),
        .begin_h(begin_h), .begin_v(begin_v),
        .h_end(h_end), .v_end(v_end), .h_found(h_found), .v_found(v_found),
        .h_wallX(h_wallX), .h_wallY(h_wallY), .v_wallX(v_wallX), .v_wallY(v_wallY),
        .col_we(col_we), .col_addr(col_addr), .col_dist(col_dist), .col_side(col_side),
        .frame_busy(frame_busy), .frame_done(frame_done)
`ifdef RAY_TIMEOUT_EN
        , .timeout_seen(timeout_seen)
`endif
    );

    int n_asserts = 0;
    int n_fails   = 0;

    // engine responder settings
    bit                 auto_en = 1'b0;
    bit                 v_en    = 1'b1;
    logic               rh_found = 1'b0, rv_found = 1'b0;
    logic signed [12:0] rhx = '0, rhy = '0, rvx = '0, rvy = '0;
    int                 h_cnt = 0, v_cnt = 0;

    always @(negedge clock) begin
        h_end = 1'b0;
        v_end = 1'b0;
        if (h_cnt > 0) begin
            h_cnt--;
            if (h_cnt == 0) begin
                h_end = 1'b1; h_found = rh_found; h_wallX = rhx; h_wallY = rhy;
            end
        end
        if (v_cnt > 0) begin
            v_cnt--;
            if (v_cnt == 0) begin
                v_end = 1'b1; v_found = rv_found; v_wallX = rvx; v_wallY = rvy;
            end
        end
        if (auto_en && begin_h) h_cnt = 3;
        if (auto_en && v_en && begin_v) v_cnt = 3;
    end

    // monitor
    int          wr_cnt = 0, beg_cnt = 0, done_cnt = 0, wr_at_done = 0;
    logic [7:0]  addr_log [0:511];
    logic [12:0] dist_log [0:511];
    logic        side_log [0:511];
    logic [9:0]  ax_log   [0:511];
    logic [9:0]  ay_log   [0:511];

    always @(negedge clock) begin
        if (col_we && wr_cnt < 512) begin
            addr_log[wr_cnt] = col_addr;
            dist_log[wr_cnt] = col_dist;
            side_log[wr_cnt] = col_side;
            wr_cnt++;
        end
        if (begin_h && beg_cnt < 512) begin
            ax_log[beg_cnt] = ray_alpha_X;
            ay_log[beg_cnt] = ray_alpha_Y;
            beg_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            wr_at_done = wr_cnt;
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_writes(input int target, input int maxc, input string tag);
        int c = 0;
        while (wr_cnt < target && c < maxc) begin
            tick();
            c++;
        end
        check(tag, 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic set_resp(input logic hf, input int hx, input int hy,
                            input logic vf, input int vx, input int vy);
        rh_found = hf; rhx = 13'(hx); rhy = 13'(hy);
        rv_found = vf; rvx = 13'(vx); rvy = 13'(vy);
    endtask

    initial begin
        int wr_base, beg_base, c, tot;

        // reset state
        repeat (3) tick();
        check("rst_col_we", 32'(col_we), 32'd0);
        check("rst_busy", 32'(frame_busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_begin_h", 32'(begin_h), 32'd0);
        check("rst_begin_v", 32'(begin_v), 32'd0);
        check("rst_dist", 32'(col_dist), 32'd0);
        check("rst_alpha_x", 32'(ray_alpha_X), 32'd0);
        resetn = 1'b1;
        tick();

        // frame A: per-column selection cases
        player_X = 13'sd100; player_Y = 13'sd100;
        view_ang_X = 10'd0; view_ang_Y = 10'd0;
        set_resp(1'b1, 200, 150, 1'b1, 180, 140);   // h d=100, v d=80
        auto_en = 1'b1;
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        check("busy_after_start", 32'(frame_busy), 32'd1);

        wait_writes(1, 60, "col0_timeout");
        check("col0_addr", 32'(addr_log[0]), 32'd0);
        check("col0_dist_nearer_v", 32'(dist_log[0]), 32'd80);
        check("col0_side", 32'(side_log[0]), 32'd1);
        check("col0_alpha_x", 32'(ax_log[0]), 32'd330);
        check("col0_alpha_y", 32'(ay_log[0]), 32'd0);
        check("ray_x_latched", 32'(ray_X), 32'd100);
        check("ray_y_latched", 32'(ray_Y), 32'd100);

        set_resp(1'b1, 150, 120, 1'b1, 130, 150);   // both d=50
        wait_writes(2, 60, "col1_timeout");
        check("col1_tie_dist", 32'(dist_log[1]), 32'd50);
        check("col1_tie_side", 32'(side_log[1]), 32'd0);
        check("col1_alpha_x", 32'(ax_log[1]), 32'd330);
        check("col1_alpha_y", 32'(ay_log[1]), 32'd384);

        set_resp(1'b1, 110, 105, 1'b0, 100, 101);   // v not found though nearer
        wait_writes(3, 60, "col2_timeout");
        check("col2_h_only_dist", 32'(dist_log[2]), 32'd10);
        check("col2_h_only_side", 32'(side_log[2]), 32'd0);

        set_resp(1'b0, 101, 100, 1'b0, 100, 101);
        wait_writes(4, 60, "col3_timeout");
        check("col3_none_dist", 32'(dist_log[3]), 32'd8191);
        check("col3_none_side", 32'(side_log[3]), 32'd0);

        set_resp(1'b0, 101, 100, 1'b1, 90, 120);
        wait_writes(5, 60, "col4_timeout");
        check("col4_v_only_dist", 32'(dist_log[4]), 32'd20);
        check("col4_v_only_side", 32'(side_log[4]), 32'd1);
        for (int i = 0; i < 5; i++)
            check("frameA_addr", 32'(addr_log[i]), 32'(i));

        // reset while col 5 is in WAIT
        c = 0;
        while (beg_cnt < 6 && c < 60) begin tick(); c++; end
        check("col5_launch_seen", 32'(beg_cnt), 32'd6);
        tick();
        resetn = 1'b0;
        auto_en = 1'b0;
        tick();
        check("midrst_col_we", 32'(col_we), 32'd0);
        check("midrst_busy", 32'(frame_busy), 32'd0);
        check("midrst_begin", 32'(begin_h), 32'd0);
        resetn = 1'b1;
        repeat (20) tick();
        check("midrst_no_writes", 32'(wr_cnt), 32'd5);
        check("midrst_idle_busy", 32'(frame_busy), 32'd0);

        // frame B: full sweep
        set_resp(1'b1, 107, 100, 1'b1, 100, 112);   // h d=7, v d=12
        auto_en  = 1'b1;
        wr_base  = wr_cnt;
        beg_base = beg_cnt;
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        wait_writes(wr_base + 50, 600, "frameB_mid_timeout");
        start_frame = 1'b1;      // must be ignored
        tick();
        start_frame = 1'b0;
        c = 0;
        while (done_cnt < 1 && c < 3000) begin tick(); c++; end
        check("frameB_done_seen", 32'(done_cnt), 32'd1);
        repeat (40) tick();
        check("frameB_writes", 32'(wr_cnt - wr_base), 32'd160);
        check("frameB_launches", 32'(beg_cnt - beg_base), 32'd160);
        check("frameB_done_once", 32'(done_cnt), 32'd1);
        check("frameB_done_after_last", 32'(wr_at_done - wr_base), 32'd160);
        check("frameB_busy_end", 32'(frame_busy), 32'd0);
        for (int i = 0; i < 160; i++) begin
            tot = i * 384;
            check("frameB_addr", 32'(addr_log[wr_base + i]), 32'(i));
            check("frameB_alpha_x", 32'(ax_log[beg_base + i]), 32'((330 + tot / 1024) % 360));
            check("frameB_alpha_y", 32'(ay_log[beg_base + i]), 32'(tot % 1024));
        end
        check("frameB_col80_x", 32'(ax_log[beg_base + 80]), 32'd0);
        check("frameB_col80_y", 32'(ay_log[beg_base + 80]), 32'd0);
        check("frameB_dist", 32'(dist_log[wr_base + 159]), 32'd7);
        check("frameB_side", 32'(side_log[wr_base + 159]), 32'd0);

`ifdef RAY_TIMEOUT_EN
        // watchdog: vertical engine never answers
        v_en = 1'b0;
        set_resp(1'b1, 140, 100, 1'b1, 100, 101);   // h d=40
        wr_base = wr_cnt;
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        wait_writes(wr_base + 1, 1300, "timeout_write_timeout");
        check("timeout_dist", 32'(dist_log[wr_base]), 32'd40);
        check("timeout_side", 32'(side_log[wr_base]), 32'd0);
        check("timeout_seen", 32'(timeout_seen), 32'd1);
        auto_en = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
